// File: rtl/stream_write_master.sv
// Buffers a valid-qualified sample stream in a FIFO and writes each sample to DDR over Avalon-MM.
// One-shot or circular capture, controlled through an 8-word CSR slave.
module stream_write_master #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ddr_waitrequest,
  output logic [ADDR_W-1:0]        ddr_addr,
  output logic                     ddr_write,
  output logic signed [DATA_W-1:0] ddr_writedata,
  input  logic [31:0]              writedata,
  output logic [31:0]              readdata,
  input  logic [2:0]               addr,
  input  logic                     read,
  input  logic                     write,
  input  logic signed [DATA_W-1:0] d_in,
  input  logic                     v,
  output logic                     done
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] PTR_ONE   = (PTR_W+1)'(1);
  localparam logic [PTR_W:0] FILL_FULL = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_next;

  logic [ADDR_W-1:0] csr_base, csr_step, sh_base, sh_step, cur_addr, addr_after;
  logic [31:0]       csr_len, sh_len, count, count_inc, words;
  logic              csr_circ, sh_circ, overflow, wrapped;
  logic              start, soft_rst, busy;

  logic signed [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W:0] wr_ptr, rd_ptr, fill;
  logic           fifo_empty, fifo_full;
  logic           accept, last, pop, push, drop, running;

  assign start      = write && (addr == 3'd4);
  assign soft_rst   = write && (addr == 3'd6);
  assign busy       = (state == RUN);
  assign running    = busy && !start;
  assign fill       = wr_ptr - rd_ptr;
  assign fifo_empty = (fill == '0);
  assign fifo_full  = (fill == FILL_FULL);
  assign accept     = ddr_write && !ddr_waitrequest;
  assign count_inc  = count + 32'd1;
  assign last       = accept && (count_inc == sh_len);
  // A one-shot capture stops issuing once its final write is accepted.
  assign pop        = running && !fifo_empty && (!ddr_write || accept) && !(last && !sh_circ);
  assign push       = running && v && (!fifo_full || pop);
  assign drop       = running && v && fifo_full && !pop;

  always_comb begin
    addr_after = cur_addr;
    if (accept) addr_after = last ? sh_base : cur_addr + sh_step;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (start) state_next = (csr_len == 32'd0) ? DONE : RUN;
      RUN: begin
        if (start)                  state_next = (csr_len == 32'd0) ? DONE : RUN;
        else if (last && !sh_circ)  state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      done  <= 1'b0;
    end else if (soft_rst) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      done  <= (state_next == DONE);
    end
  end

  // CSR registers and read port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csr_base <= '0;
      csr_len  <= '0;
      csr_step <= ADDR_W'(1);
      csr_circ <= 1'b0;
      readdata <= '0;
    end else if (soft_rst) begin
      csr_base <= '0;
      csr_len  <= '0;
      csr_step <= ADDR_W'(1);
      csr_circ <= 1'b0;
      readdata <= '0;
    end else begin
      if (write) begin
        case (addr)
          3'd0: csr_base <= ADDR_W'(writedata);
          3'd1: csr_len  <= writedata;
          3'd2: csr_step <= ADDR_W'(writedata);
          3'd3: csr_circ <= writedata[0];
          default: ;
        endcase
      end
      if (read) begin
        case (addr)
          3'd0:    readdata <= 32'(csr_base);
          3'd1:    readdata <= csr_len;
          3'd2:    readdata <= 32'(csr_step);
          3'd3:    readdata <= {31'd0, csr_circ};
          3'd5:    readdata <= {28'd0, wrapped, overflow, busy, done};
          3'd7:    readdata <= words;
          default: readdata <= 32'hDEAD_BEEF;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PTR_W-1:0]] <= d_in;
  end

  // Capture datapath: shadow config, FIFO pointers and the Avalon master
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_base <= '0; sh_step <= '0; sh_len <= '0; sh_circ <= 1'b0;
      cur_addr <= '0; count <= '0; words <= '0;
      overflow <= 1'b0; wrapped <= 1'b0;
      wr_ptr <= '0; rd_ptr <= '0;
      ddr_write <= 1'b0; ddr_addr <= '0; ddr_writedata <= '0;
    end else if (soft_rst) begin
      sh_base <= '0; sh_step <= '0; sh_len <= '0; sh_circ <= 1'b0;
      cur_addr <= '0; count <= '0; words <= '0;
      overflow <= 1'b0; wrapped <= 1'b0;
      wr_ptr <= '0; rd_ptr <= '0;
      ddr_write <= 1'b0; ddr_addr <= '0; ddr_writedata <= '0;
    end else if (start) begin
      sh_base  <= csr_base;
      sh_step  <= csr_step;
      sh_len   <= csr_len;
      sh_circ  <= csr_circ;
      cur_addr <= csr_base;
      count    <= '0;
      words    <= '0;
      overflow <= 1'b0;
      wrapped  <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ddr_write <= 1'b0;
    end else if (state != RUN) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ddr_write <= 1'b0;
    end else begin
      cur_addr <= addr_after;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (drop) overflow <= 1'b1;
      if (accept) begin
        count <= (last && sh_circ) ? 32'd0 : count_inc;
        words <= words + 32'd1;
        if (last && sh_circ) wrapped <= 1'b1;
      end
      if (pop) begin
        ddr_write     <= 1'b1;
        ddr_addr      <= addr_after;
        ddr_writedata <= mem[rd_ptr[PTR_W-1:0]];
        rd_ptr        <= rd_ptr + PTR_ONE;
      end else if (accept) begin
        ddr_write <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_write_master.sv
// Self-checking bench for stream_write_master: table-driven capture runs with a write scoreboard,
// plus hand-written overflow, zero-length, restart and reset sequences.
module tb_stream_write_master;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 32;
  localparam int unsigned FD = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 ddr_waitrequest;
  logic [AW-1:0]        ddr_addr;
  logic                 ddr_write;
  logic signed [DW-1:0] ddr_writedata;
  logic [31:0]          writedata;
  logic [31:0]          readdata;
  logic [2:0]           addr;
  logic                 read;
  logic                 write;
  logic signed [DW-1:0] d_in;
  logic                 v;
  logic                 done;

  stream_write_master #(.DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .ddr_waitrequest(ddr_waitrequest), .ddr_addr(ddr_addr),
    .ddr_write(ddr_write), .ddr_writedata(ddr_writedata), .writedata(writedata),
    .readdata(readdata), .addr(addr), .read(read), .write(write), .d_in(d_in),
    .v(v), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [15:0] d;
  } wr_t;

  typedef struct {
    logic [31:0] base;
    logic [31:0] step;
    logic [31:0] len;
    bit          circ;
    int          nsamp;
    int          stall_at;
    int          stall_len;
    logic [31:0] exp_status;
    logic [31:0] exp_words;
  } vec_t;

  typedef struct {
    logic [2:0]  a;
    logic [31:0] exp;
  } rvec_t;

  wr_t   exp_q[$];
  vec_t  vecs[5];
  rvec_t rtab[8];

  int checks = 0;
  int errors = 0;
  int stall_cycles = 0;
  bit mon_hold_en = 1'b1;
  bit prev_stall = 1'b0;
  logic [31:0] hold_addr;
  logic [15:0] hold_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Bus monitor: scoreboard compare on accepted writes, stability check while stalled
  always @(negedge clk) begin
    wr_t e;
    if (rst || !mon_hold_en) begin
      prev_stall = 1'b0;
    end
    if (!rst) begin
      if (mon_hold_en && prev_stall) begin
        checks++;
        if (!(ddr_write && ddr_addr === hold_addr && $unsigned(ddr_writedata) === hold_data)) begin
          errors++;
          $display("FAIL hold: got write=%0b addr=0x%08h data=0x%04h expected write=1 addr=0x%08h data=0x%04h",
                   ddr_write, ddr_addr, ddr_writedata, hold_addr, hold_data);
        end
      end
      if (ddr_write && ddr_waitrequest) begin
        prev_stall   = mon_hold_en;
        hold_addr    = ddr_addr;
        hold_data    = $unsigned(ddr_writedata);
        stall_cycles++;
      end else begin
        prev_stall = 1'b0;
      end
      if (ddr_write && !ddr_waitrequest) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: got addr=0x%08h data=0x%04h expected no write", ddr_addr, ddr_writedata);
        end else begin
          e = exp_q.pop_front();
          if (ddr_addr !== e.a || $unsigned(ddr_writedata) !== e.d) begin
            errors++;
            $display("FAIL write: got addr=0x%08h data=0x%04h expected addr=0x%08h data=0x%04h",
                     ddr_addr, ddr_writedata, e.a, e.d);
          end
        end
      end
    end
  end

  task automatic csr_write(input logic [2:0] a, input logic [31:0] d);
    write = 1'b1; addr = a; writedata = d;
    @(posedge clk); #1;
    write = 1'b0;
  endtask

  task automatic csr_read(input logic [2:0] a, output logic [31:0] d);
    read = 1'b1; addr = a;
    @(posedge clk); #1;
    read = 1'b0;
    d = readdata;
  endtask

  task automatic wait_drain(input int maxc);
    int n = 0;
    while (exp_q.size() != 0 && n < maxc) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("drain_remaining", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic run_vec(input int k);
    vec_t t;
    logic [31:0] rd;
    logic [31:0] idx;
    wr_t w;
    t = vecs[k];
    csr_write(3'd6, 32'd0);
    csr_write(3'd0, t.base);
    csr_write(3'd1, t.len);
    csr_write(3'd2, t.step);
    csr_write(3'd3, {31'd0, t.circ});
    for (int i = 0; i < t.nsamp; i++) begin
      if (t.circ || 32'(i) < t.len) begin
        idx = t.circ ? (32'(i) % t.len) : 32'(i);
        w.a = t.base + t.step * idx;
        w.d = 16'((k << 8) + i + 1);
        exp_q.push_back(w);
      end
    end
    stall_cycles = 0;
    csr_write(3'd4, 32'd0);
    for (int c = 0; c < t.nsamp + t.stall_len + 8; c++) begin
      v = (c < t.nsamp);
      d_in = 16'((k << 8) + c + 1);
      ddr_waitrequest = (t.stall_len > 0) && (c >= t.stall_at + 2) && (c < t.stall_at + 2 + t.stall_len);
      @(posedge clk); #1;
    end
    v = 1'b0;
    ddr_waitrequest = 1'b0;
    wait_drain(50);
    csr_read(3'd5, rd);
    chk($sformatf("vec%0d_status", k), rd, t.exp_status);
    csr_read(3'd7, rd);
    chk($sformatf("vec%0d_words", k), rd, t.exp_words);
    chk($sformatf("vec%0d_done", k), {31'd0, done}, {31'd0, t.exp_status[0]});
    chk($sformatf("vec%0d_stall_cycles", k), 32'(stall_cycles), 32'(t.stall_len));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    wr_t w;

    vecs[0] = '{32'h100, 32'd2, 32'd4, 1'b0, 4, 0, 0, 32'h1, 32'd4};
    vecs[1] = '{32'h100, 32'd2, 32'd4, 1'b0, 4, 1, 3, 32'h1, 32'd4};
    vecs[2] = '{32'h0,   32'd1, 32'd3, 1'b1, 7, 0, 0, 32'hA, 32'd7};
    vecs[3] = '{32'hFFFF_FFFE, 32'd1, 32'd3, 1'b0, 3, 0, 0, 32'h1, 32'd3};
    vecs[4] = '{32'h40,  32'd4, 32'd2, 1'b1, 5, 0, 0, 32'hA, 32'd5};

    rtab[0] = '{3'd0, 32'd0};
    rtab[1] = '{3'd1, 32'd0};
    rtab[2] = '{3'd2, 32'd1};
    rtab[3] = '{3'd3, 32'd0};
    rtab[4] = '{3'd4, 32'hDEAD_BEEF};
    rtab[5] = '{3'd5, 32'd0};
    rtab[6] = '{3'd6, 32'hDEAD_BEEF};
    rtab[7] = '{3'd7, 32'd0};

    rst = 1'b1; ddr_waitrequest = 1'b0; writedata = '0; addr = '0;
    read = 1'b0; write = 1'b0; d_in = '0; v = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ddr_write", {31'd0, ddr_write}, 32'd0);
    chk("reset_ddr_addr", ddr_addr, 32'd0);
    chk("reset_ddr_writedata", 32'($unsigned(ddr_writedata)), 32'd0);
    chk("reset_readdata", readdata, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      csr_read(rtab[i].a, rd);
      chk($sformatf("reset_csr%0d", i), rd, rtab[i].exp);
    end

    for (int k = 0; k < 5; k++) run_vec(k);

    // Soft reset restores defaults after the table left step/base modified
    csr_write(3'd2, 32'd7);
    csr_write(3'd0, 32'h1234);
    csr_write(3'd6, 32'd0);
    csr_read(3'd2, rd); chk("softrst_step", rd, 32'd1);
    csr_read(3'd0, rd); chk("softrst_base", rd, 32'd0);

    // Overflow: bus stalled, 7 samples, only 1 pending + FD buffered survive
    csr_write(3'd0, 32'h200);
    csr_write(3'd1, 32'd5);
    csr_write(3'd2, 32'd1);
    csr_write(3'd3, 32'd0);
    for (int i = 0; i < 5; i++) begin
      w.a = 32'h200 + 32'(i);
      w.d = 16'(16'h31 + i);
      exp_q.push_back(w);
    end
    ddr_waitrequest = 1'b1;
    csr_write(3'd4, 32'd0);
    for (int c = 0; c < 7; c++) begin
      v = 1'b1; d_in = 16'(16'h31 + c);
      @(posedge clk); #1;
    end
    v = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    csr_read(3'd5, rd); chk("ovf_status_stalled", rd, 32'h6);
    ddr_waitrequest = 1'b0;
    wait_drain(50);
    csr_read(3'd5, rd); chk("ovf_status_done", rd, 32'h5);
    csr_read(3'd7, rd); chk("ovf_words", rd, 32'd5);

    // Zero length: done on the start edge, samples ignored
    csr_write(3'd6, 32'd0);
    csr_write(3'd1, 32'd0);
    csr_write(3'd4, 32'd0);
    chk("len0_done", {31'd0, done}, 32'd1);
    for (int c = 0; c < 3; c++) begin
      v = 1'b1; d_in = 16'(16'h77 + c);
      @(posedge clk); #1;
    end
    v = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    csr_read(3'd5, rd); chk("len0_status", rd, 32'h1);
    csr_read(3'd7, rd); chk("len0_words", rd, 32'd0);

    // Restart mid-run abandons the stalled write and clears overflow
    csr_write(3'd6, 32'd0);
    csr_write(3'd0, 32'h300);
    csr_write(3'd1, 32'd8);
    ddr_waitrequest = 1'b1;
    csr_write(3'd4, 32'd0);
    for (int c = 0; c < 6; c++) begin
      v = 1'b1; d_in = 16'(16'h41 + c);
      @(posedge clk); #1;
    end
    v = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    csr_read(3'd5, rd); chk("restart_status_before", rd, 32'h6);
    chk("restart_pending", {31'd0, ddr_write}, 32'd1);
    mon_hold_en = 1'b0;
    csr_write(3'd0, 32'h400);
    csr_write(3'd1, 32'd2);
    csr_write(3'd4, 32'd0);
    chk("restart_write_dropped", {31'd0, ddr_write}, 32'd0);
    csr_read(3'd5, rd); chk("restart_status_after", rd, 32'h2);
    mon_hold_en = 1'b1;
    w.a = 32'h400; w.d = 16'h51; exp_q.push_back(w);
    w.a = 32'h401; w.d = 16'h52; exp_q.push_back(w);
    ddr_waitrequest = 1'b0;
    for (int c = 0; c < 2; c++) begin
      v = 1'b1; d_in = 16'(16'h51 + c);
      @(posedge clk); #1;
    end
    v = 1'b0;
    wait_drain(50);
    csr_read(3'd5, rd); chk("restart_status_done", rd, 32'h1);
    csr_read(3'd7, rd); chk("restart_words", rd, 32'd2);

    // Async reset while a write is pending
    csr_write(3'd6, 32'd0);
    csr_write(3'd0, 32'h500);
    csr_write(3'd1, 32'd4);
    ddr_waitrequest = 1'b1;
    csr_write(3'd4, 32'd0);
    for (int c = 0; c < 2; c++) begin
      v = 1'b1; d_in = 16'(16'h61 + c);
      @(posedge clk); #1;
    end
    v = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pending_before", {31'd0, ddr_write}, 32'd1);
    mon_hold_en = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_async_write", {31'd0, ddr_write}, 32'd0);
    chk("rst_async_addr", ddr_addr, 32'd0);
    chk("rst_async_data", 32'($unsigned(ddr_writedata)), 32'd0);
    chk("rst_async_done", {31'd0, done}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    ddr_waitrequest = 1'b0;
    mon_hold_en = 1'b1;
    csr_read(3'd5, rd); chk("rst_status", rd, 32'd0);
    csr_read(3'd0, rd); chk("rst_base", rd, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
